// File: rtl/fwrisc_dbus_responder.sv
// FWRISC data-bus target: routes each request to SRAM or test MMIO (tohost/scratch/cycle).
// Latency 2+WAIT_STATES cycles to a one-cycle dready; one transfer in flight, next accept only from IDLE.
module fwrisc_dbus_responder #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int WAIT_STATES   = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              daddr,
    input  logic [31:0]              dwdata,
    input  logic [3:0]               dwstb,
    input  logic                     dwrite,
    input  logic                     dvalid,
    output logic [31:0]              drdata,
    output logic                     dready,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     mem_we,
    input  logic [31:0]              mem_rdata,
    output logic [31:0]              tohost,
    output logic                     done,
    output logic                     pass,
    output logic                     bus_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [7:0] WAIT_LOAD = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;

    localparam logic [1:0] OFF_TOHOST  = 2'd0;
    localparam logic [1:0] OFF_SCRATCH = 2'd1;
    localparam logic [1:0] OFF_CYCLE   = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [7:0]               wcnt_q, wcnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [31:0]              wdata_q;
    logic [3:0]               strb_q;
    logic                     write_q;
    logic                     mmio_q;
    logic                     unmapped_q;
    logic [1:0]               off_q;

    logic [31:0]              tohost_q;
    logic [31:0]              scratch_q;
    logic [31:0]              cycle_q;
    logic [31:0]              mmio_rd_q;
    logic                     done_q;
    logic                     pass_q;
    logic                     bus_err_q;

    logic                     accept;
    logic                     issue;
    logic                     unused_addr;

    assign accept      = (state_q == S_IDLE) && dvalid;
    assign issue       = (state_q == S_ISSUE);
    assign unused_addr = ^daddr[1:0];

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (dvalid) begin
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ISSUE;
                    wcnt_d  = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 8'd0) begin
                    state_d = S_ISSUE;
                end else begin
                    wcnt_d = wcnt_q - 8'd1;
                end
            end
            S_ISSUE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request is decoded and frozen at accept; later bus activity cannot disturb it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wcnt_q     <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            strb_q     <= 4'd0;
            write_q    <= 1'b0;
            mmio_q     <= 1'b0;
            unmapped_q <= 1'b0;
            off_q      <= 2'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (accept) begin
                addr_q     <= daddr[ADDRESS_WIDTH+1:2];
                wdata_q    <= dwdata;
                strb_q     <= dwstb;
                write_q    <= dwrite;
                mmio_q     <= daddr[31];
                off_q      <= daddr[3:2];
                unmapped_q <= (|daddr[30:4]) || (daddr[3:2] == 2'd3);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tohost_q  <= 32'd0;
            scratch_q <= 32'd0;
            cycle_q   <= 32'd0;
            mmio_rd_q <= 32'd0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (issue && mmio_q) begin
                if (unmapped_q) begin
                    bus_err_q <= 1'b1;
                    mmio_rd_q <= 32'd0;
                end else if (write_q) begin
                    case (off_q)
                        OFF_TOHOST: begin
                            tohost_q <= wdata_q;
                            done_q   <= 1'b1;
                            pass_q   <= (wdata_q == 32'd1);
                        end
                        OFF_SCRATCH: begin
                            for (int b = 0; b < 4; b++) begin
                                if (strb_q[b]) begin
                                    scratch_q[8*b +: 8] <= wdata_q[8*b +: 8];
                                end
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    case (off_q)
                        OFF_TOHOST:  mmio_rd_q <= tohost_q;
                        OFF_SCRATCH: mmio_rd_q <= scratch_q;
                        OFF_CYCLE:   mmio_rd_q <= cycle_q;
                        default:     mmio_rd_q <= 32'd0;
                    endcase
                end
            end
        end
    end

    // Reset gates the combinational strobes so an in-flight pulse never escapes.
    assign mem_addr  = issue ? addr_q : '0;
    assign mem_wdata = issue ? wdata_q : 32'd0;
    assign mem_be    = issue ? strb_q : 4'd0;
    assign mem_we    = issue && !mmio_q && write_q && !reset;

    assign dready = (state_q == S_RESP) && !reset;
    assign drdata = (!dready || write_q) ? 32'd0 : (mmio_q ? mmio_rd_q : mem_rdata);

    assign tohost  = tohost_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_fwrisc_dbus_responder.sv
// Scoreboarded bench: three responders (0, 3 and 4 wait states) on a shared bus with per-instance dvalid.
module tb_fwrisc_dbus_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwstb;
    logic        dwrite;
    logic [2:0]  dvalid;

    logic [31:0] drdata    [3];
    logic        dready    [3];
    logic [13:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [3:0]  mem_be    [3];
    logic        mem_we    [3];
    logic [31:0] tohost    [3];
    logic        done      [3];
    logic        pass      [3];
    logic        bus_err   [3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int rel   = 0;

    logic [31:0] exp_dat [3][64];
    int          exp_lat [3][64];
    int          iss_cyc [3][64];
    int          wp [3] = '{0, 0, 0};
    int          rp [3] = '{0, 0, 0};

    int          we_cnt  [3] = '{0, 0, 0};
    logic [13:0] we_addr [3];
    logic [3:0]  we_be   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] rdata;
        logic [31:0] ram [16384];

        fwrisc_dbus_responder #(
            .ADDRESS_WIDTH(14),
            .WAIT_STATES  (g == 0 ? 0 : (g == 1 ? 3 : 4))
        ) u_dut (
            .clock    (clk),
            .reset    (rst),
            .daddr    (daddr),
            .dwdata   (dwdata),
            .dwstb    (dwstb),
            .dwrite   (dwrite),
            .dvalid   (dvalid[g]),
            .drdata   (drdata[g]),
            .dready   (dready[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_be   (mem_be[g]),
            .mem_we   (mem_we[g]),
            .mem_rdata(rdata),
            .tohost   (tohost[g]),
            .done     (done[g]),
            .pass     (pass[g]),
            .bus_err  (bus_err[g])
        );

        always @(posedge clk) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[g] && mem_be[g][b]) ram[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
            rdata <= ram[mem_addr[g]];
        end
    end

    // Monitor: pops one expectation per dready and also records SRAM write pulses.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mem_we[i]) begin
                we_cnt[i]  = we_cnt[i] + 1;
                we_addr[i] = mem_addr[i];
                we_be[i]   = mem_be[i];
            end
            if (dready[i]) begin
                total = total + 1;
                if (rp[i] == wp[i]) begin
                    bad = bad + 1;
                    $display("FAIL resp%0d unexpected dready actual drdata=%h required no response", i, drdata[i]);
                end else begin
                    if (drdata[i] !== exp_dat[i][rp[i]] || (cyc - iss_cyc[i][rp[i]]) != exp_lat[i][rp[i]]) begin
                        bad = bad + 1;
                        $display("FAIL resp%0d#%0d actual data=%h lat=%0d required data=%h lat=%0d",
                                 i, rp[i], drdata[i], cyc - iss_cyc[i][rp[i]],
                                 exp_dat[i][rp[i]], exp_lat[i][rp[i]]);
                    end
                    rp[i] = rp[i] + 1;
                end
            end
        end
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that ends RESP.
    task automatic req(input int d, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s, input logic wr, input logic [31:0] e);
        int n = 0;
        exp_dat[d][wp[d]] = e;
        exp_lat[d][wp[d]] = 2 + ws_of(d);
        iss_cyc[d][wp[d]] = cyc;
        wp[d] = wp[d] + 1;
        daddr  = a;
        dwdata = w;
        dwstb  = s;
        dwrite = wr;
        dvalid[d] = 1'b1;
        @(posedge clk);
        #1;
        dvalid[d] = 1'b0;
        daddr  = $urandom;
        dwdata = $urandom;
        dwstb  = 4'($urandom);
        dwrite = ~wr;
        do begin
            @(negedge clk);
            n++;
        end while (!dready[d] && n < 40);
        if (!dready[d]) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL timeout%0d actual=no dready required=dready within 40 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int i);
        chk($sformatf("rst_flags%0d", i),
            {27'd0, dready[i], mem_we[i], done[i], pass[i], bus_err[i]}, 32'd0);
        chk($sformatf("rst_drdata%0d", i), drdata[i], 32'd0);
        chk($sformatf("rst_mem_addr%0d", i), {18'd0, mem_addr[i]}, 32'd0);
        chk($sformatf("rst_mem_wdata%0d", i), mem_wdata[i], 32'd0);
        chk($sformatf("rst_mem_be%0d", i), {28'd0, mem_be[i]}, 32'd0);
        chk($sformatf("rst_tohost%0d", i), tohost[i], 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        daddr  = 32'd0;
        dwdata = 32'd0;
        dwstb  = 4'd0;
        dwrite = 1'b0;
        dvalid = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rel = cyc;
        for (int i = 0; i < 3; i++) chk_reset(i);

        // SRAM word write/read, zero wait states
        req(0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'd0);
        chk("we_count", 32'(we_cnt[0]), 32'd1);
        chk("we_addr", {18'd0, we_addr[0]}, 32'h40);
        req(0, 32'h0000_0100, 32'd0, 4'hF, 1'b0, 32'hDEAD_BEEF);

        // byte strobes
        req(0, 32'h0000_0200, 32'h1122_3344, 4'hF, 1'b1, 32'd0);
        req(0, 32'h0000_0200, 32'hAABB_CCDD, 4'h2, 1'b1, 32'd0);
        chk("we_be", {28'd0, we_be[0]}, 32'h2);
        req(0, 32'h0000_0200, 32'd0, 4'hF, 1'b0, 32'h1122_CC44);

        // aliasing above the SRAM window
        req(0, 32'h0001_0100, 32'd0, 4'hF, 1'b0, 32'hDEAD_BEEF);

        // TOHOST
        req(0, 32'h8000_0000, 32'h1, 4'h0, 1'b1, 32'd0);
        chk("done_1", {31'd0, done[0]}, 32'd1);
        chk("pass_1", {31'd0, pass[0]}, 32'd1);
        req(0, 32'h8000_0000, 32'h5, 4'hF, 1'b1, 32'd0);
        chk("tohost_5", tohost[0], 32'h5);
        chk("pass_5", {31'd0, pass[0]}, 32'd0);
        chk("done_5", {31'd0, done[0]}, 32'd1);
        req(0, 32'h8000_0000, 32'd0, 4'hF, 1'b0, 32'h5);

        // CYCLE: writes ignored without error; reads track cycles since reset
        req(0, 32'h8000_0008, 32'h1234_5678, 4'hF, 1'b1, 32'd0);
        chk("cycle_wr_no_err", {31'd0, bus_err[0]}, 32'd0);
        req(0, 32'h8000_0008, 32'd0, 4'hF, 1'b0, 32'(cyc + 1 - rel));
        repeat (7) @(posedge clk);
        #1;
        req(0, 32'h8000_0008, 32'd0, 4'hF, 1'b0, 32'(cyc + 1 - rel));

        // SCRATCH with strobes, low address bits ignored
        req(0, 32'h8000_0004, 32'hCAFE_F00D, 4'hC, 1'b1, 32'd0);
        req(0, 32'h8000_0004, 32'd0, 4'hF, 1'b0, 32'hCAFE_0000);
        req(0, 32'h8000_0007, 32'd0, 4'hF, 1'b0, 32'hCAFE_0000);

        // unmapped offset
        req(0, 32'h8000_000C, 32'd0, 4'hF, 1'b0, 32'd0);
        chk("bus_err_off3", {31'd0, bus_err[0]}, 32'd1);

        // three wait states
        req(1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 1'b1, 32'd0);
        req(1, 32'h0000_0000, 32'd0, 4'hF, 1'b0, 32'h0BAD_F00D);
        req(1, 32'h8000_0010, 32'h1, 4'hF, 1'b1, 32'd0);
        chk("bus_err_hi", {31'd0, bus_err[1]}, 32'd1);
        chk("done_hi", {31'd0, done[1]}, 32'd0);

        // reset in WAIT aborts the write with no strobes
        daddr  = 32'h0000_0400;
        dwdata = 32'h9999_9999;
        dwstb  = 4'hF;
        dwrite = 1'b1;
        dvalid[2] = 1'b1;
        @(posedge clk);
        #1;
        dvalid[2] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) chk_reset(i);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_we", 32'(we_cnt[2]), 32'd0);
        req(2, 32'h0000_0300, 32'h1234_5678, 4'hF, 1'b1, 32'd0);
        req(2, 32'h0000_0300, 32'd0, 4'hF, 1'b0, 32'h1234_5678);
        chk("post_rst_we", 32'(we_cnt[2]), 32'd1);
        chk("post_rst_addr", {18'd0, we_addr[2]}, 32'hC0);

        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("drain%0d", i), 32'(rp[i]), 32'(wp[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwrisc_dbus_responder.md
# fwrisc_dbus_responder

Target-side responder for the FWRISC core data bus (`daddr`/`dwdata`/`dwstb`/`dwrite`/`dvalid` → `drdata`/`dready`). It replaces the tied-high `dready` in the unit testbench with a real handshake. It routes each transfer either to a synchronous single-port SRAM port or to a small test-control MMIO block (tohost, scratch, cycle counter). A programmable wait-state count lets the bench stress the core's stall handling.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 14, SRAM word-address width (64 KiB at default).
- `WAIT_STATES`, 0, extra cycles inserted between request accept and SRAM/MMIO issue (0..255).

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `daddr`  in  32  byte address from core.
- `dwdata`  in  32  write data.
- `dwstb`  in  4  byte strobes; bit n enables byte lane n.
- `dwrite`  in  1  1 = write, 0 = read.
- `dvalid`  in  1  request valid.
- `drdata`  out  32  read data; valid only while `dready`=1.
- `dready`  out  1  one-cycle completion pulse.
- `mem_addr`  out  ADDRESS_WIDTH  SRAM word address.
- `mem_wdata`  out  32  SRAM write data.
- `mem_be`  out  4  SRAM byte enables.
- `mem_we`  out  1  SRAM write enable.
- `mem_rdata`  in  32  SRAM read data, one-cycle latency.
- `tohost`  out  32  last value written to TOHOST.
- `done`  out  1  sticky; set by any TOHOST write.
- `pass`  out  1  set with `done`; 1 iff the value written was 32'h1.
- `bus_err`  out  1  sticky; set by an access to an unmapped MMIO offset.

## Operation
- Decode:
  - `daddr[31]`=0 selects SRAM, word address `daddr[ADDRESS_WIDTH+1:2]`. Upper bits are ignored, so the SRAM aliases.
  - `daddr[31]`=1 selects MMIO. `daddr[30:4]` must be 0, else unmapped.
  - Offset `daddr[3:2]`: 0=TOHOST (RW), 1=SCRATCH (RW, byte-strobed), 2=CYCLE (RO), 3=unmapped.
  - `daddr[1:0]` is ignored.
- FSM states IDLE, WAIT, ISSUE, RESP:
  - IDLE: when `dvalid`=1, capture addr, wdata, strb, write and region. Go to WAIT if `WAIT_STATES`>0 (counter loaded with `WAIT_STATES`-1), else ISSUE.
  - WAIT: decrement the counter. Go to ISSUE when the counter is 0.
  - ISSUE: drive `mem_addr`, `mem_wdata` and `mem_be` from the captured request. `mem_we`=1 only for an SRAM write. MMIO writes and reads are performed this cycle. Go to RESP.
  - RESP: `dready`=1. `drdata` = `mem_rdata` for an SRAM read, the registered MMIO read value for an MMIO read, or 0 for any write. Go to IDLE.
- MMIO rules:
  - A TOHOST write stores the full word, ignores `dwstb`, sets `done`, and sets `pass` to (wdata==1).
  - A later TOHOST write overwrites `tohost` and `pass`; `done` stays 1.
  - CYCLE is a 32-bit free-running counter from reset. It wraps 0xFFFFFFFF→0. Writes to CYCLE are ignored without an error.
  - An unmapped read returns 0; an unmapped write is dropped. Both set `bus_err` and still complete normally with `dready`.
- The captured request is used from accept onward. Changes on the bus inputs, including `dvalid` dropping, do not affect an in-flight transfer.

## Timing
- Reset values: `dready`=0, `drdata`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `tohost`=0, `done`=0, `pass`=0, `bus_err`=0, CYCLE=0, SCRATCH=0, FSM=IDLE.
- Latency: request sampled in IDLE at edge E0. ISSUE is the cycle after E0+`WAIT_STATES`. `dready` is high one cycle after ISSUE. With `WAIT_STATES`=0, `dready` is high in the 2nd cycle after the `dvalid` cycle.
- `dready` is high for exactly one cycle per accepted request and is never asserted twice for one request.
- A request is not accepted in RESP. The core drops or renews `dvalid` after sampling `dready`, and the next request is accepted in IDLE the following cycle. Maximum throughput is one transfer per 3+`WAIT_STATES` cycles.
- `reset` asserted in any state returns to IDLE next edge. It suppresses a pending `dready` and any pending `mem_we`.
- `mem_we` is a single-cycle pulse, only in ISSUE.

## Test plan
- SRAM word write/read, `WAIT_STATES`=0: write 0xDEADBEEF to 0x100 (`dwstb`=0xF), then read 0x100. Required: `mem_we` pulse with `mem_addr`=0x40; read `drdata`=0xDEADBEEF; each `dready` is 2 cycles after its `dvalid`.
- Byte strobes: write 0x11223344 to 0x200, then write 0xAABBCCDD with `dwstb`=0x2. Required: read returns 0x1122CC44.
- Wait states: `WAIT_STATES`=3, read 0x0. Required: `dready` exactly 5 cycles after `dvalid` and `dready` high for 1 cycle only.
- TOHOST: write 0x1 to 0x80000000. Required: `done`=1, `pass`=1. Then write 0x5. Required: `tohost`=5, `pass`=0, `done`=1.
- MMIO misc:
  - Read CYCLE twice 10 cycles apart. Required: difference 10.
  - SCRATCH write 0xCAFEF00D, `dwstb`=0xC, then read. Required: 0xCAFE0000.
  - Read 0x8000000C. Required: 0 and `bus_err`=1.
- Reset mid-transfer: `WAIT_STATES`=4, issue a write, assert `reset` during WAIT. Required: no `mem_we`, no `dready`, all outputs at reset values. The next request completes normally.
